// File: rtl/rename_pkg.sv
// rename_pkg: shared widths and types for the rename map and its checkpoints
package rename_pkg;
   localparam int NUM_AREGS  = 32;
   localparam int NUM_PREGS  = 64;
   localparam int NUM_LANES  = 2;
   localparam int CKPT_DEPTH = 4;
   localparam int ZERO_REG   = 1;
   localparam int AW = $clog2(NUM_AREGS);
   localparam int PW = $clog2(NUM_PREGS);
   localparam int CW = $clog2(CKPT_DEPTH);
   localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   typedef logic [AW-1:0] areg_t;
   typedef logic [PW-1:0] preg_t;
   typedef logic [CW-1:0] ckpt_tag_t;
   typedef logic [CW:0] ckpt_cnt_t;
   typedef logic [LW-1:0] lane_t;
   typedef preg_t [NUM_AREGS-1:0] map_t;
endpackage

// File: rtl/rat_ckpt_if.sv
// rat_ckpt_if: rename lanes and checkpoint control between rename logic and the alias table
interface rat_ckpt_if import rename_pkg::*; ();
   logic [NUM_LANES-1:0] ren_valid;
   areg_t [NUM_LANES-1:0] ren_arch_dst;
   preg_t [NUM_LANES-1:0] ren_phys_dst;
   areg_t [NUM_LANES-1:0] ren_arch_src1;
   areg_t [NUM_LANES-1:0] ren_arch_src2;
   preg_t [NUM_LANES-1:0] ren_phys_src1;
   preg_t [NUM_LANES-1:0] ren_phys_src2;
   preg_t [NUM_LANES-1:0] ren_old_phys_dst;
   logic ckpt_alloc;
   lane_t ckpt_lane;
   ckpt_tag_t ckpt_tag;
   logic ckpt_full;
   ckpt_cnt_t ckpt_count;
   logic restore_valid;
   ckpt_tag_t restore_tag;
   logic release_valid;
   modport master (
      output ren_valid, ren_arch_dst, ren_phys_dst, ren_arch_src1, ren_arch_src2,
      output ckpt_alloc, ckpt_lane, restore_valid, restore_tag, release_valid,
      input ren_phys_src1, ren_phys_src2, ren_old_phys_dst, ckpt_tag, ckpt_full, ckpt_count
   );
   modport slave (
      input ren_valid, ren_arch_dst, ren_phys_dst, ren_arch_src1, ren_arch_src2,
      input ckpt_alloc, ckpt_lane, restore_valid, restore_tag, release_valid,
      output ren_phys_src1, ren_phys_src2, ren_old_phys_dst, ckpt_tag, ckpt_full, ckpt_count
   );
endinterface

// File: rtl/rat_ckpt_bypass.sv
// rat_ckpt_bypass: one lookup for lane LANE, overriding the map with the youngest older lane's write
module rat_ckpt_bypass import rename_pkg::*; #(
   parameter int LANE = 0
) (
   input  areg_t                 arch,
   input  preg_t                 map_val,
   input  logic [NUM_LANES-1:0]  we,
   input  areg_t [NUM_LANES-1:0] arch_dst,
   input  preg_t [NUM_LANES-1:0] phys_dst,
   output preg_t                 phys
);
   // ascending scan so the youngest matching older lane overrides last
   always_comb begin
      phys = (ZERO_REG != 0 && arch == '0) ? '0 : map_val;
      for (int j = 0; j < NUM_LANES; j++)
         if (j < LANE && we[j] && arch_dst[j] == arch) phys = phys_dst[j];
   end
endmodule

// File: rtl/rat_ckpt.sv
// rat_ckpt: multi-lane register alias table with a circular stack of branch checkpoints
module rat_ckpt import rename_pkg::*; (
   input logic     clk,
   input logic     reset,
   rat_ckpt_if.slave rif
);
   map_t map_q, map_new, map_ck;
   map_t [CKPT_DEPTH-1:0] snap_q;
   ckpt_tag_t head_q, tail_q, head_n, cnt_tag, rel_pos;
   ckpt_cnt_t count_q;
   logic [NUM_LANES-1:0] we;
   logic rel, full, alloc_ok;
   preg_t [NUM_LANES-1:0] src1, src2, old_dst;

   assign full     = count_q == ckpt_cnt_t'(CKPT_DEPTH);
   assign rel      = rif.release_valid && count_q != '0;
   assign alloc_ok = rif.ckpt_alloc && (!full || rel);
   assign head_n   = head_q + ckpt_tag_t'(rel);
   assign cnt_tag  = rif.restore_tag - head_n + ckpt_tag_t'(1);
   assign rel_pos  = rif.restore_tag - head_q;

   assign rif.ren_phys_src1    = src1;
   assign rif.ren_phys_src2    = src2;
   assign rif.ren_old_phys_dst = old_dst;
   assign rif.ckpt_tag         = tail_q;
   assign rif.ckpt_full        = full;
   assign rif.ckpt_count       = count_q;

   // next map after all lanes, and the partial map up to the branch lane for the snapshot
   always_comb begin
      map_new = map_q;
      map_ck  = map_q;
      for (int l = 0; l < NUM_LANES; l++) begin
         we[l] = rif.ren_valid[l] && !(ZERO_REG != 0 && rif.ren_arch_dst[l] == '0);
         if (we[l]) map_new[rif.ren_arch_dst[l]] = rif.ren_phys_dst[l];
         if (we[l] && lane_t'(l) <= rif.ckpt_lane) map_ck[rif.ren_arch_dst[l]] = rif.ren_phys_dst[l];
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      rat_ckpt_bypass #(.LANE(k)) u_src1 (
         .arch(rif.ren_arch_src1[k]), .map_val(map_q[rif.ren_arch_src1[k]]), .we(we),
         .arch_dst(rif.ren_arch_dst), .phys_dst(rif.ren_phys_dst), .phys(src1[k])
      );
      rat_ckpt_bypass #(.LANE(k)) u_src2 (
         .arch(rif.ren_arch_src2[k]), .map_val(map_q[rif.ren_arch_src2[k]]), .we(we),
         .arch_dst(rif.ren_arch_dst), .phys_dst(rif.ren_phys_dst), .phys(src2[k])
      );
      rat_ckpt_bypass #(.LANE(k)) u_old (
         .arch(rif.ren_arch_dst[k]), .map_val(map_q[rif.ren_arch_dst[k]]), .we(we),
         .arch_dst(rif.ren_arch_dst), .phys_dst(rif.ren_phys_dst), .phys(old_dst[k])
      );
   end

   // map and stack pointers: restore overrides same-cycle renames and allocation
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_AREGS; i++) map_q[i] <= preg_t'(i);
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (rif.restore_valid) begin
         map_q   <= snap_q[rif.restore_tag];
         head_q  <= head_n;
         tail_q  <= rif.restore_tag + ckpt_tag_t'(1);
         count_q <= (cnt_tag == '0) ? ckpt_cnt_t'(CKPT_DEPTH) : {1'b0, cnt_tag};
      end else begin
         map_q   <= map_new;
         head_q  <= head_n;
         tail_q  <= tail_q + ckpt_tag_t'(alloc_ok);
         count_q <= count_q + ckpt_cnt_t'(alloc_ok) - ckpt_cnt_t'(rel);
      end
   end

   // snapshot store needs no reset; contents are only read once allocated
   always_ff @(posedge clk) begin
      if (!reset && !rif.restore_valid && alloc_ok) snap_q[tail_q] <= map_ck;
   end

`ifndef SYNTHESIS
   // flag protocol misuse by the rename/branch units
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(rif.ckpt_alloc && !rif.restore_valid && full && !rif.release_valid))
            else $warning("checkpoint alloc dropped while full");
         assert (!(rif.release_valid && count_q == '0))
            else $error("checkpoint release with no live checkpoint");
         assert (!(rif.restore_valid && {1'b0, rel_pos} >= count_q))
            else $error("restore of a non-live checkpoint");
         assert (!(rif.restore_valid && rif.release_valid && rif.restore_tag == head_q))
            else $error("restore of the checkpoint being released");
      end
   end
`endif
endmodule

// File: tb/tb_rat_ckpt.sv
// tb_rat_ckpt: directed checks of lookup, bypass, checkpoint, restore and release
module tb_rat_ckpt;
   import rename_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;

   rat_ckpt_if rif();
   rat_ckpt dut (.clk(clk), .reset(reset), .rif(rif.slave));

   always #5 clk = ~clk;

   task automatic idle();
      rif.ren_valid = '0;
      rif.ren_arch_dst = '0;
      rif.ren_phys_dst = '0;
      rif.ren_arch_src1 = '0;
      rif.ren_arch_src2 = '0;
      rif.ckpt_alloc = 1'b0;
      rif.ckpt_lane = '0;
      rif.restore_valid = 1'b0;
      rif.restore_tag = '0;
      rif.release_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      rif.ren_arch_src1[0] = 5'd5;
      rif.ren_arch_src2[0] = 5'd0;
      rif.ren_arch_src1[1] = 5'd31;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd5) begin errors++; $display("FAIL reset_r5 got %0d exp 5", rif.ren_phys_src1[0]); end
      checks++; if (rif.ren_phys_src2[0] !== 6'd0) begin errors++; $display("FAIL reset_r0 got %0d exp 0", rif.ren_phys_src2[0]); end
      checks++; if (rif.ren_phys_src1[1] !== 6'd31) begin errors++; $display("FAIL reset_r31 got %0d exp 31", rif.ren_phys_src1[1]); end
      checks++; if (rif.ckpt_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", rif.ckpt_count); end
      checks++; if (rif.ckpt_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", rif.ckpt_full); end
      checks++; if (rif.ckpt_tag !== 2'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", rif.ckpt_tag); end
   endtask

   task automatic test_bypass();
      idle();
      rif.ren_valid = 2'b01;
      rif.ren_arch_dst[0] = 5'd3;
      rif.ren_phys_dst[0] = 6'd40;
      rif.ren_arch_src1[0] = 5'd3;
      rif.ren_arch_src1[1] = 5'd3;
      #1;
      checks++; if (rif.ren_phys_src1[1] !== 6'd40) begin errors++; $display("FAIL bypass_lane1 got %0d exp 40", rif.ren_phys_src1[1]); end
      checks++; if (rif.ren_old_phys_dst[0] !== 6'd3) begin errors++; $display("FAIL bypass_old0 got %0d exp 3", rif.ren_old_phys_dst[0]); end
      checks++; if (rif.ren_phys_src1[0] !== 6'd3) begin errors++; $display("FAIL bypass_noself got %0d exp 3", rif.ren_phys_src1[0]); end
      tick();
      idle();
      rif.ren_arch_src1[0] = 5'd3;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd40) begin errors++; $display("FAIL bypass_next got %0d exp 40", rif.ren_phys_src1[0]); end
   endtask

   task automatic test_same_arch();
      idle();
      rif.ren_valid = 2'b11;
      rif.ren_arch_dst[0] = 5'd7;
      rif.ren_arch_dst[1] = 5'd7;
      rif.ren_phys_dst[0] = 6'd41;
      rif.ren_phys_dst[1] = 6'd42;
      rif.ren_arch_src1[0] = 5'd7;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd7) begin errors++; $display("FAIL same_src0 got %0d exp 7", rif.ren_phys_src1[0]); end
      checks++; if (rif.ren_old_phys_dst[1] !== 6'd41) begin errors++; $display("FAIL same_old1 got %0d exp 41", rif.ren_old_phys_dst[1]); end
      tick();
      idle();
      rif.ren_arch_src1[0] = 5'd7;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd42) begin errors++; $display("FAIL same_youngest got %0d exp 42", rif.ren_phys_src1[0]); end
   endtask

   task automatic test_zero_reg();
      idle();
      rif.ren_valid = 2'b01;
      rif.ren_arch_dst[0] = 5'd0;
      rif.ren_phys_dst[0] = 6'd60;
      rif.ren_arch_src1[1] = 5'd0;
      #1;
      checks++; if (rif.ren_phys_src1[1] !== 6'd0) begin errors++; $display("FAIL zero_nobypass got %0d exp 0", rif.ren_phys_src1[1]); end
      checks++; if (rif.ren_old_phys_dst[1] !== 6'd0) begin errors++; $display("FAIL zero_old1 got %0d exp 0", rif.ren_old_phys_dst[1]); end
      tick();
      idle();
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd0) begin errors++; $display("FAIL zero_nowrite got %0d exp 0", rif.ren_phys_src1[0]); end
   endtask

   task automatic test_ckpt_restore();
      idle();
      rif.ren_valid = 2'b11;
      rif.ren_arch_dst[0] = 5'd2;
      rif.ren_arch_dst[1] = 5'd2;
      rif.ren_phys_dst[0] = 6'd50;
      rif.ren_phys_dst[1] = 6'd51;
      rif.ckpt_alloc = 1'b1;
      #1;
      checks++; if (rif.ckpt_tag !== 2'd0) begin errors++; $display("FAIL ck_tag_before got %0d exp 0", rif.ckpt_tag); end
      tick();
      idle();
      rif.ren_arch_src1[0] = 5'd2;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd51) begin errors++; $display("FAIL ck_r2_live got %0d exp 51", rif.ren_phys_src1[0]); end
      checks++; if (rif.ckpt_count !== 3'd1) begin errors++; $display("FAIL ck_count1 got %0d exp 1", rif.ckpt_count); end
      checks++; if (rif.ckpt_tag !== 2'd1) begin errors++; $display("FAIL ck_tag1 got %0d exp 1", rif.ckpt_tag); end
      rif.restore_valid = 1'b1;
      rif.restore_tag = 2'd0;
      tick();
      idle();
      rif.ren_arch_src1[0] = 5'd2;
      rif.ren_arch_src2[0] = 5'd3;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd50) begin errors++; $display("FAIL rs_r2 got %0d exp 50", rif.ren_phys_src1[0]); end
      checks++; if (rif.ren_phys_src2[0] !== 6'd40) begin errors++; $display("FAIL rs_r3 got %0d exp 40", rif.ren_phys_src2[0]); end
      checks++; if (rif.ckpt_count !== 3'd1) begin errors++; $display("FAIL rs_count got %0d exp 1", rif.ckpt_count); end
      checks++; if (rif.ckpt_tag !== 2'd1) begin errors++; $display("FAIL rs_tag got %0d exp 1", rif.ckpt_tag); end
      rif.release_valid = 1'b1;
      tick();
      idle();
      #1;
      checks++; if (rif.ckpt_count !== 3'd0) begin errors++; $display("FAIL rel_count got %0d exp 0", rif.ckpt_count); end
   endtask

   task automatic test_full_wrap();
      reset = 1'b1;
      idle();
      rif.ckpt_alloc = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      rif.ren_arch_src1[0] = 5'd3;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd3) begin errors++; $display("FAIL midreset_r3 got %0d exp 3", rif.ren_phys_src1[0]); end
      checks++; if (rif.ckpt_count !== 3'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", rif.ckpt_count); end
      rif.ckpt_alloc = 1'b1;
      repeat (4) tick();
      rif.ckpt_alloc = 1'b0;
      #1;
      checks++; if (rif.ckpt_full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b exp 1", rif.ckpt_full); end
      checks++; if (rif.ckpt_count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", rif.ckpt_count); end
      checks++; if (rif.ckpt_tag !== 2'd0) begin errors++; $display("FAIL fill_tag got %0d exp 0", rif.ckpt_tag); end
      rif.ckpt_alloc = 1'b1;
      tick();
      rif.ckpt_alloc = 1'b0;
      #1;
      checks++; if (rif.ckpt_count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d exp 4", rif.ckpt_count); end
      checks++; if (rif.ckpt_tag !== 2'd0) begin errors++; $display("FAIL drop_tag got %0d exp 0", rif.ckpt_tag); end
      rif.ckpt_alloc = 1'b1;
      rif.release_valid = 1'b1;
      tick();
      idle();
      #1;
      checks++; if (rif.ckpt_count !== 3'd4) begin errors++; $display("FAIL allocrel_count got %0d exp 4", rif.ckpt_count); end
      checks++; if (rif.ckpt_tag !== 2'd1) begin errors++; $display("FAIL allocrel_tag got %0d exp 1", rif.ckpt_tag); end
      checks++; if (rif.ckpt_full !== 1'b1) begin errors++; $display("FAIL allocrel_full got %0b exp 1", rif.ckpt_full); end
   endtask

   task automatic test_restore_discard();
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rif.ren_valid = 2'b01;
         rif.ren_arch_dst[0] = 5'd10;
         rif.ren_phys_dst[0] = preg_t'(20 + i);
         rif.ckpt_alloc = 1'b1;
         tick();
      end
      idle();
      rif.ren_arch_src1[0] = 5'd10;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd23) begin errors++; $display("FAIL disc_r10_pre got %0d exp 23", rif.ren_phys_src1[0]); end
      checks++; if (rif.ckpt_count !== 3'd4) begin errors++; $display("FAIL disc_count_pre got %0d exp 4", rif.ckpt_count); end
      rif.restore_valid = 1'b1;
      rif.restore_tag = 2'd1;
      rif.ckpt_alloc = 1'b1;
      rif.ren_valid = 2'b11;
      rif.ren_arch_dst[0] = 5'd10;
      rif.ren_arch_dst[1] = 5'd11;
      rif.ren_phys_dst[0] = 6'd60;
      rif.ren_phys_dst[1] = 6'd61;
      tick();
      idle();
      rif.ren_arch_src1[0] = 5'd10;
      rif.ren_arch_src1[1] = 5'd11;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd21) begin errors++; $display("FAIL disc_r10 got %0d exp 21", rif.ren_phys_src1[0]); end
      checks++; if (rif.ren_phys_src1[1] !== 6'd11) begin errors++; $display("FAIL disc_r11_lost got %0d exp 11", rif.ren_phys_src1[1]); end
      checks++; if (rif.ckpt_count !== 3'd2) begin errors++; $display("FAIL disc_count got %0d exp 2", rif.ckpt_count); end
      checks++; if (rif.ckpt_tag !== 2'd2) begin errors++; $display("FAIL disc_tag got %0d exp 2", rif.ckpt_tag); end
      checks++; if (rif.ckpt_full !== 1'b0) begin errors++; $display("FAIL disc_full got %0b exp 0", rif.ckpt_full); end
      rif.restore_valid = 1'b1;
      rif.restore_tag = 2'd1;
      rif.release_valid = 1'b1;
      tick();
      idle();
      #1;
      checks++; if (rif.ckpt_count !== 3'd1) begin errors++; $display("FAIL rsrel_count got %0d exp 1", rif.ckpt_count); end
      checks++; if (rif.ckpt_tag !== 2'd2) begin errors++; $display("FAIL rsrel_tag got %0d exp 2", rif.ckpt_tag); end
   endtask

   task automatic test_lane_cut();
      idle();
      rif.ren_valid = 2'b11;
      rif.ren_arch_dst[0] = 5'd12;
      rif.ren_arch_dst[1] = 5'd13;
      rif.ren_phys_dst[0] = 6'd30;
      rif.ren_phys_dst[1] = 6'd31;
      rif.ckpt_alloc = 1'b1;
      rif.ckpt_lane = 1'b0;
      tick();
      idle();
      rif.restore_valid = 1'b1;
      rif.restore_tag = 2'd2;
      tick();
      idle();
      rif.ren_arch_src1[0] = 5'd12;
      rif.ren_arch_src2[0] = 5'd13;
      #1;
      checks++; if (rif.ren_phys_src1[0] !== 6'd30) begin errors++; $display("FAIL cut_r12 got %0d exp 30", rif.ren_phys_src1[0]); end
      checks++; if (rif.ren_phys_src2[0] !== 6'd13) begin errors++; $display("FAIL cut_r13 got %0d exp 13", rif.ren_phys_src2[0]); end
      checks++; if (rif.ckpt_count !== 3'd2) begin errors++; $display("FAIL cut_count got %0d exp 2", rif.ckpt_count); end
      checks++; if (rif.ckpt_tag !== 2'd3) begin errors++; $display("FAIL cut_tag got %0d exp 3", rif.ckpt_tag); end
   endtask

   initial begin
      idle();
      test_reset();
      test_bypass();
      test_same_arch();
      test_zero_reg();
      test_ckpt_restore();
      test_full_wrap();
      test_restore_discard();
      test_lane_cut();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
